// File: rtl/mux_16.sv
// Registered 16-way word selector: out <= word S of the packed bus when en=1, else hold.
// One cycle select-to-output latency, no backpressure; en=0 simply freezes out.
module mux_16 #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [16*WIDTH-1:0] in,
  input  logic [3:0]          S,
  input  logic                en,
  output logic [WIDTH-1:0]    out
);

  logic [WIDTH-1:0] words [16];
  logic [WIDTH-1:0] sel_word;

  // Unpack lanes so the select becomes a plain array index; word 0 sits at the LSBs.
  for (genvar k = 0; k < 16; k++) begin : g_unpack
    assign words[k] = in[WIDTH*k +: WIDTH];
  end

  always_comb begin
    sel_word = words[S];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (en) begin
      out <= sel_word;
    end
  end

endmodule

// File: tb/tb_mux_16.sv
// Directed self-checking bench for mux_16 with hand-computed expected words.
module tb_mux_16;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_bus;
  logic [3:0]   S;
  logic         en;
  logic [15:0]  out;

  int checks = 0;
  int errors = 0;

  mux_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_bus),
    .S     (S),
    .en    (en),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_onehot();
    for (int j = 0; j < 16; j++) in_bus[j*16 +: 16] = 16'(1 << j);
  endtask

  logic [255:0] bus_a;
  logic [31:0]  r;
  logic [15:0]  exp_w;

  initial begin
    rst_n  = 1'b1;
    en     = 1'b1;
    S      = 4'd4;
    in_bus = '0;
    load_onehot();
    step();
    chk("pre_reset_load", out, 16'h0010);

    // Asynchronous reset asserted between edges.
    #2 rst_n = 1'b0;
    #1 chk("reset_async", out, 16'h0000);
    step();
    chk("reset_hold_edge1", out, 16'h0000);
    step();
    chk("reset_hold_edge2", out, 16'h0000);
    rst_n = 1'b1;

    // One-hot sweep.
    for (int k = 0; k < 16; k++) begin
      S = 4'(k);
      step();
      chk($sformatf("onehot_s%0d", k), out, 16'(1 << k));
    end

    // Boundary words: word0 at LSBs, word15 at [255:240].
    in_bus = '0;
    in_bus[15:0]    = 16'hA5A5;
    in_bus[255:240] = 16'h5A5A;
    S = 4'd0;  step(); chk("bound_s0_a",  out, 16'hA5A5);
    S = 4'd15; step(); chk("bound_s15",   out, 16'h5A5A);
    S = 4'd0;  step(); chk("bound_s0_b",  out, 16'hA5A5);

    // Enable hold.
    in_bus = '0;
    in_bus[63:48] = 16'h1234;
    S = 4'd3;
    step();
    chk("hold_load", out, 16'h1234);
    en = 1'b0;
    S  = 4'd7;
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < 16; j++) begin
        r = $urandom();
        in_bus[j*16 +: 16] = r[15:0];
      end
      step();
      chk($sformatf("hold_c%0d", c), out, 16'h1234);
    end
    exp_w = in_bus[127:112];
    en = 1'b1;
    step();
    chk("hold_release_w7", out, exp_w);

    // Simultaneous S and bus change.
    for (int j = 0; j < 16; j++) in_bus[j*16 +: 16] = 16'h1100 + 16'(j);
    S = 4'd2;
    step();
    chk("simul_before", out, 16'h1102);
    for (int j = 0; j < 16; j++) bus_a[j*16 +: 16] = 16'hC000 + 16'(j * 16'h0101);
    in_bus = bus_a;
    S = 4'd9;
    step();
    chk("simul_after", out, 16'hC909);

    // Mid-stream reset during a one-hot sweep.
    load_onehot();
    for (int k = 0; k < 10; k++) begin
      S = 4'(k);
      if (k == 6) begin
        #3 rst_n = 1'b0;
        #1 chk("midreset_async", out, 16'h0000);
        #1 rst_n = 1'b1;
      end
      step();
      chk($sformatf("midsweep_s%0d", k), out, 16'(1 << k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
